// File: rtl/multi_alien_renderer.sv
// Depth-resolving sprite address generator for the aliens of one screen quadrant.
// A shadow descriptor table is promoted to the active table on frame_start.
package alien_pkg;
    typedef struct packed {
        logic       active;
        logic [1:0] quadrant;
        logic [9:0] x_pos;
        logic [9:0] y_pos;
        logic [5:0] r;
        logic [1:0] deriv_left;
        logic [1:0] deriv_right;
    } AlienData;
endpackage

module multi_alien_renderer
    import alien_pkg::*;
#(
    parameter int NUM_SLOTS        = 4,
    parameter int QUADRANT         = 0,
    parameter int X_OVERFLOW_GUARD = 128,
    parameter int SCALE_SHIFT      = 2,
    parameter int BASE_HALF        = 32,
    parameter int ADDR_W           = 11,
    localparam int SLOT_W          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              frame_start,
    input  logic              obj_we,
    input  logic [SLOT_W-1:0] obj_idx,
    input  AlienData          obj_data,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [1:0]        deriv_select,
    output logic [SLOT_W-1:0] slot_id,
    output logic              valid,
    output logic              overlap,
    output logic              in_frame
);

    localparam int S = 1 << SCALE_SHIFT;

    function automatic logic eligible(input AlienData d);
        return d.active && (d.quadrant == 2'(QUADRANT)) && (32'(d.r) < BASE_HALF);
    endfunction

    AlienData shadow   [NUM_SLOTS];
    AlienData act_tab  [NUM_SLOTS];

    // Write-through: a write coinciding with frame_start lands in both tables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i]  <= '0;
                act_tab[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (obj_we && obj_idx == SLOT_W'(i))
                    shadow[i] <= obj_data;
                if (frame_start)
                    act_tab[i] <= (obj_we && obj_idx == SLOT_W'(i)) ? obj_data : shadow[i];
            end
        end
    end

    logic                     elig_c [NUM_SLOTS];
    logic [5:0]               hw_c   [NUM_SLOTS];
    logic [11:0]              hws_c  [NUM_SLOTS];
    logic signed [11:0]       top_c  [NUM_SLOTS];
    logic signed [11:0]       bot_c  [NUM_SLOTS];
    logic                     any_elig_c;

    always_comb begin
        any_elig_c = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            elig_c[i] = eligible(act_tab[i]);
            hw_c[i]   = 6'(BASE_HALF) - act_tab[i].r;
            hws_c[i]  = 12'(hw_c[i]) << SCALE_SHIFT;
            top_c[i]  = $signed({2'b00, act_tab[i].y_pos}) - $signed(hws_c[i]);
            bot_c[i]  = $signed({2'b00, act_tab[i].y_pos}) + $signed(hws_c[i]);
            any_elig_c = any_elig_c | elig_c[i];
        end
    end

    // Stage 1: scan position and per-slot bounds
    logic [9:0]         hg_p0, v_p0;
    logic               elig_p0 [NUM_SLOTS];
    logic [5:0]         hw_p0   [NUM_SLOTS];
    logic [5:0]         r_p0    [NUM_SLOTS];
    logic [9:0]         x_p0    [NUM_SLOTS];
    logic [1:0]         dl_p0   [NUM_SLOTS];
    logic [1:0]         dr_p0   [NUM_SLOTS];
    logic signed [11:0] top_p0  [NUM_SLOTS];
    logic signed [11:0] bot_p0  [NUM_SLOTS];
    logic               in_any_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hg_p0     <= '0;
            v_p0      <= '0;
            in_any_p0 <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                elig_p0[i] <= 1'b0;
                hw_p0[i]   <= '0;
                r_p0[i]    <= '0;
                x_p0[i]    <= '0;
                dl_p0[i]   <= '0;
                dr_p0[i]   <= '0;
                top_p0[i]  <= '0;
                bot_p0[i]  <= '0;
            end
        end else begin
            hg_p0     <= h_cnt + 10'(X_OVERFLOW_GUARD);
            v_p0      <= v_cnt;
            in_any_p0 <= any_elig_c;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                elig_p0[i] <= elig_c[i];
                hw_p0[i]   <= hw_c[i];
                r_p0[i]    <= act_tab[i].r;
                x_p0[i]    <= act_tab[i].x_pos;
                dl_p0[i]   <= act_tab[i].deriv_left;
                dr_p0[i]   <= act_tab[i].deriv_right;
                top_p0[i]  <= top_c[i];
                bot_p0[i]  <= bot_c[i];
            end
        end
    end

    logic signed [11:0] vs_c;
    logic [11:0]        hws1_c [NUM_SLOTS];
    logic               right_c[NUM_SLOTS];
    logic [9:0]         dx_c   [NUM_SLOTS];
    logic [11:0]        dy_c   [NUM_SLOTS];
    logic               hit_c  [NUM_SLOTS];
    logic [ADDR_W-1:0]  addr_c [NUM_SLOTS];
    logic [1:0]         deriv_c[NUM_SLOTS];

    // The left half is mirrored and one texel narrower so column 0 is shared.
    always_comb begin
        vs_c = $signed({2'b00, v_p0});
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hws1_c[i]  = 12'(hw_p0[i]) << SCALE_SHIFT;
            right_c[i] = hg_p0 >= x_p0[i];
            dx_c[i]    = right_c[i] ? (hg_p0 - x_p0[i]) : (x_p0[i] - hg_p0);
            dy_c[i]    = vs_c - top_p0[i];
            hit_c[i]   = elig_p0[i] && (vs_c > top_p0[i]) && (vs_c < bot_p0[i]) &&
                         (right_c[i] ? (12'(dx_c[i]) < hws1_c[i])
                                     : (12'(dx_c[i]) < hws1_c[i] - 12'(S)));
            addr_c[i]  = ADDR_W'(18'(dy_c[i] >> SCALE_SHIFT) * 18'(hw_p0[i])
                                 + 18'(dx_c[i] >> SCALE_SHIFT));
            deriv_c[i] = right_c[i] ? dr_p0[i] : dl_p0[i];
        end
    end

    // Stage 2: per-slot hit, address and derivative
    logic              hit_p1   [NUM_SLOTS];
    logic [ADDR_W-1:0] addr_p1  [NUM_SLOTS];
    logic [1:0]        deriv_p1 [NUM_SLOTS];
    logic [5:0]        r_p1     [NUM_SLOTS];
    logic              in_any_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_any_p1 <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                hit_p1[i]   <= 1'b0;
                addr_p1[i]  <= '0;
                deriv_p1[i] <= '0;
                r_p1[i]     <= '0;
            end
        end else begin
            in_any_p1 <= in_any_p0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                hit_p1[i]   <= hit_c[i];
                addr_p1[i]  <= addr_c[i];
                deriv_p1[i] <= deriv_c[i];
                r_p1[i]     <= r_p0[i];
            end
        end
    end

    logic              any_c, multi_c;
    logic [SLOT_W-1:0] best_c;
    logic [5:0]        best_r_c;

    // Strict less-than keeps the lowest index on equal depth.
    always_comb begin
        any_c    = 1'b0;
        multi_c  = 1'b0;
        best_c   = '0;
        best_r_c = '1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit_p1[i]) begin
                if (!any_c || r_p1[i] < best_r_c) begin
                    best_c   = SLOT_W'(i);
                    best_r_c = r_p1[i];
                end
                multi_c = multi_c | any_c;
                any_c   = 1'b1;
            end
        end
    end

    // Stage 3: resolved outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr   <= '0;
            deriv_select <= '0;
            slot_id      <= '0;
            valid        <= 1'b0;
            overlap      <= 1'b0;
            in_frame     <= 1'b0;
        end else begin
            pixel_addr   <= any_c ? addr_p1[best_c]  : '0;
            deriv_select <= any_c ? deriv_p1[best_c] : '0;
            slot_id      <= any_c ? best_c : '0;
            valid        <= any_c;
            overlap      <= multi_c;
            in_frame     <= in_any_p1;
        end
    end

endmodule

// File: tb/tb_multi_alien_renderer.sv
// Directed bench for multi_alien_renderer: geometry edges, depth priority,
// double buffering, eligibility filtering and asynchronous reset.
module tb_multi_alien_renderer;
    import alien_pkg::*;

    localparam int NUM_SLOTS = 3;
    localparam int SLOT_W    = 2;
    localparam int ADDR_W    = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [9:0]        h_cnt = '0;
    logic [9:0]        v_cnt = '0;
    logic              frame_start = 1'b0;
    logic              obj_we = 1'b0;
    logic [SLOT_W-1:0] obj_idx = '0;
    AlienData          obj_data = '0;
    logic [ADDR_W-1:0] pixel_addr;
    logic [1:0]        deriv_select;
    logic [SLOT_W-1:0] slot_id;
    logic              valid, overlap, in_frame;

    int errors = 0;
    int checks = 0;

    multi_alien_renderer #(.NUM_SLOTS(NUM_SLOTS)) dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .frame_start(frame_start), .obj_we(obj_we), .obj_idx(obj_idx),
        .obj_data(obj_data), .pixel_addr(pixel_addr), .deriv_select(deriv_select),
        .slot_id(slot_id), .valid(valid), .overlap(overlap), .in_frame(in_frame)
    );

    always #5 clk = ~clk;

    function automatic AlienData mk(input logic a, input logic [1:0] q, input logic [9:0] x,
                                    input logic [9:0] y, input logic [5:0] r,
                                    input logic [1:0] dl, input logic [1:0] dr);
        AlienData d;
        d.active = a; d.quadrant = q; d.x_pos = x; d.y_pos = y;
        d.r = r; d.deriv_left = dl; d.deriv_right = dr;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic wr(input logic [SLOT_W-1:0] idx, input AlienData d);
        obj_we = 1'b1; obj_idx = idx; obj_data = d;
        @(negedge clk);
        obj_we = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        settle();
    endtask

    task automatic pix(input logic [9:0] h, input logic [9:0] v);
        h_cnt = h; v_cnt = v;
        settle();
    endtask

    task automatic hit(input string tag, input int addr, input int dsel, input int sid, input int ovl);
        chk({tag, ".valid"}, 32'(valid), 1);
        chk({tag, ".addr"},  32'(pixel_addr), 32'(addr));
        chk({tag, ".deriv"}, 32'(deriv_select), 32'(dsel));
        chk({tag, ".slot"},  32'(slot_id), 32'(sid));
        chk({tag, ".ovl"},   32'(overlap), 32'(ovl));
    endtask

    task automatic miss(input string tag);
        chk({tag, ".valid"}, 32'(valid), 0);
        chk({tag, ".addr"},  32'(pixel_addr), 0);
        chk({tag, ".slot"},  32'(slot_id), 0);
    endtask

    AlienData s0;

    initial begin
        s0 = mk(1'b1, 2'd0, 10'd400, 10'd240, 6'd16, 2'd1, 2'd2);
        h_cnt = 10'd272; v_cnt = 10'd240;
        repeat (2) @(negedge clk);
        miss("reset");
        chk("reset.in_frame", 32'(in_frame), 0);
        chk("reset.ovl", 32'(overlap), 0);
        rst = 1'b0;
        settle();

        // shadow write alone is invisible
        wr(2'd0, s0);
        settle();
        miss("pre_fs");
        fs();
        hit("basic", 256, 2, 0, 0);
        chk("basic.in_frame", 32'(in_frame), 1);

        // exact 3-cycle latency: 256 -> 0 when v moves to 177
        v_cnt = 10'd177;
        @(posedge clk); @(posedge clk); #1;
        chk("lat.old", 32'(pixel_addr), 256);
        @(posedge clk); #1;
        chk("lat.new", 32'(pixel_addr), 0);
        settle();

        pix(10'd271, 10'd240); hit("mirror", 256, 1, 0, 0);
        pix(10'd272, 10'd176); miss("top_edge");
        pix(10'd272, 10'd177); hit("top_in", 0, 2, 0, 0);
        pix(10'd272, 10'd303); hit("bot_in", 496, 2, 0, 0);
        pix(10'd272, 10'd304); miss("bot_edge");
        pix(10'd336, 10'd240); miss("right_edge");
        pix(10'd335, 10'd240); hit("right_in", 271, 2, 0, 0);
        pix(10'd212, 10'd240); miss("left_edge");
        pix(10'd213, 10'd240); hit("left_in", 270, 1, 0, 0);

        // depth priority
        pix(10'd272, 10'd240);
        wr(2'd1, mk(1'b1, 2'd0, 10'd400, 10'd240, 6'd8, 2'd0, 2'd3));
        fs();
        hit("near", 576, 3, 1, 1);
        wr(2'd1, mk(1'b1, 2'd0, 10'd400, 10'd240, 6'd16, 2'd0, 2'd3));
        fs();
        hit("tie", 256, 2, 0, 1);
        wr(2'd1, '0);
        fs();
        hit("single", 256, 2, 0, 0);

        // double buffering
        wr(2'd0, mk(1'b0, 2'd0, 10'd400, 10'd240, 6'd16, 2'd1, 2'd2));
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("hold.valid", 32'(valid), 1);
        end
        fs();
        miss("cleared");
        chk("cleared.in_frame", 32'(in_frame), 0);

        obj_we = 1'b1; obj_idx = 2'd0; obj_data = s0; frame_start = 1'b1;
        @(negedge clk);
        obj_we = 1'b0; frame_start = 1'b0;
        settle();
        hit("wthru", 256, 2, 0, 0);

        // ineligible descriptors
        wr(2'd0, mk(1'b1, 2'd1, 10'd400, 10'd240, 6'd16, 2'd1, 2'd2));
        fs();
        miss("quad1");
        chk("quad1.in_frame", 32'(in_frame), 0);
        wr(2'd0, mk(1'b1, 2'd0, 10'd400, 10'd240, 6'd32, 2'd1, 2'd2));
        fs();
        miss("r32");
        chk("r32.in_frame", 32'(in_frame), 0);
        wr(2'd0, s0);
        fs();
        hit("restore", 256, 2, 0, 0);
        wr(2'd3, mk(1'b1, 2'd0, 10'd400, 10'd240, 6'd4, 2'd3, 2'd3));
        fs();
        hit("idx_oob", 256, 2, 0, 0);

        // asynchronous reset while valid
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        miss("rst_async");
        chk("rst_async.in_frame", 32'(in_frame), 0);
        @(negedge clk);
        rst = 1'b0;
        settle();
        miss("post_rst");
        fs();
        miss("post_rst_fs");
        wr(2'd0, s0);
        fs();
        hit("rewrite", 256, 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_alien_renderer.md
Name: multi_alien_renderer

Overview:
- Pipelined sprite-address generator for up to NUM_SLOTS aliens in one screen quadrant, driven by the VGA scan counters.
- Object descriptors are written into a shadow table at any time. They become visible only on a frame_start pulse, which gives tear-free updates.
- For each pixel the block resolves overlapping aliens by depth and emits one sprite ROM address, derivative select, winning slot id and valid flag to the pixel mux.

Parameters:
- NUM_SLOTS, 4: number of object slots; minimum 1.
- QUADRANT, 0: quadrant id this instance renders; slots with another _quadrant are ignored.
- X_OVERFLOW_GUARD, 128: offset added to h_cnt before comparing with _x_pos.
- SCALE_SHIFT, 2: log2 of the screen pixels per sprite texel (S = 1<<SCALE_SHIFT).
- BASE_HALF, 32: sprite half-size in texels at _r = 0.
- ADDR_W, 11: pixel_addr width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- h_cnt  in  10  horizontal scan count
- v_cnt  in  10  vertical scan count
- frame_start  in  1  single-cycle pulse at start of vblank; copies the shadow table to the active table
- obj_we  in  1  shadow table write strobe
- obj_idx  in  $clog2(NUM_SLOTS) (min 1)  shadow slot to write
- obj_data  in  AlienData  descriptor (_active, _quadrant, _x_pos, _y_pos, _r, _deriv_left, _deriv_right)
- pixel_addr  out  ADDR_W  sprite ROM address of the winning slot
- deriv_select  out  2  derivative frame select of the winning slot
- slot_id  out  $clog2(NUM_SLOTS) (min 1)  index of the winning slot
- valid  out  1  current pixel lies inside at least one sprite
- overlap  out  1  two or more slots hit the current pixel
- in_frame  out  1  at least one active slot belongs to QUADRANT

Behaviour:
- Reset (async): both tables cleared to _active=0; all outputs 0; pipeline registers 0.
- Table write: obj_we writes obj_data to shadow[obj_idx]. An obj_idx >= NUM_SLOTS is ignored.
- frame_start copies shadow to active in one cycle. If obj_we coincides with frame_start, the new data is written to shadow and is also what lands in active (write-through).
- Per-slot geometry:
  - A slot is eligible when _active=1, _quadrant==QUADRANT and _r < BASE_HALF.
  - hw = BASE_HALF - _r (square sprite).
  - hg = h_cnt + X_OVERFLOW_GUARD, computed at 10 bits.
  - top = _y_pos - hw*S, computed signed 12-bit so there is no wraparound.
- Per-slot hit (vertical): hit requires top < v_cnt < _y_pos + hw*S, both bounds strict.
- Per-slot hit (horizontal):
  - Right side (hg >= _x_pos): hg - _x_pos < hw*S; xaddr = (hg - _x_pos)>>SCALE_SHIFT; deriv = _deriv_right.
  - Left side (hg < _x_pos, mirrored): _x_pos - hg < hw*S - S; xaddr = (_x_pos - hg)>>SCALE_SHIFT; deriv = _deriv_left.
- Address: yaddr = (v_cnt - top)>>SCALE_SHIFT; addr = yaddr*hw + xaddr, truncated to ADDR_W.
- Pipeline, with a fixed latency of 3 clk from h_cnt/v_cnt to all outputs:
  - Stage 1 registers hg, v_cnt and the bounds.
  - Stage 2 registers the per-slot hit, addr and deriv.
  - Stage 3 registers the resolved outputs.
- Priority at stage 3:
  - Among hitting slots, the smallest _r (nearest) wins; a tie goes to the lowest index.
  - valid = any hit; overlap = hit count >= 2.
  - When valid=0, pixel_addr, deriv_select and slot_id hold 0.
- in_frame: registered OR of eligible slots, aligned to the same 3-cycle latency.
- A frame_start mid-line takes effect for pixels entering stage 1 on the next cycle; no pipeline flush.
- Reset mid-operation: outputs drop immediately. After reset release, nothing is valid until a slot is written and frame_start is pulsed.

Test Plan:
- Basic hit, right side:
  - Setup: slot0 {active=1, quad=0, x=400, y=240, r=16, dr=2, dl=1} written, then frame_start; h_cnt=272, v_cnt=240.
  - Expected 3 clk later: valid=1, pixel_addr=256, deriv_select=2, slot_id=0, overlap=0.
- Mirror and edges, same slot:
  - h_cnt=271 -> pixel_addr=256, deriv_select=1.
  - v_cnt=176 -> valid=0; v_cnt=177 -> valid=1, pixel_addr=0.
  - h_cnt=336 (right edge) -> valid=0.
- Depth priority:
  - Setup: add slot1 at the same x/y with r=8; h_cnt=272, v_cnt=240.
  - Expected: slot_id=1, pixel_addr=576, overlap=1.
  - Then set slot1 r=16: tie -> slot_id=0.
- Double buffering:
  - Shadow-write slot0 active=0 without frame_start -> output unchanged for 100 clk.
  - After a frame_start pulse -> valid=0, in_frame=0.
  - Simultaneous obj_we and frame_start -> the new data takes effect.
- Ineligible slots: quadrant=1, r=32, or obj_idx=NUM_SLOTS -> valid=0 and no table change.
- Reset while valid=1 -> all outputs 0 in the same cycle; valid stays 0 after release until rewrite plus frame_start.
